// File: rtl/output_serializer.sv
// output_serializer: buffers CPU output nibbles in a FIFO and sends each as a
// UART-style frame (start, 4 data bits LSB first, stop) on a registered tx line.
module output_serializer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic [3:0] output_data,
   input  logic out_valid,
   output logic out_ready,
   input  logic clear_overflow,
   output logic tx,
   output logic tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state;
   logic [3:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [3:0] shreg;
   logic push, pop, full, tick;
   assign full = count == FULL;
   assign push = out_valid && !full;
   assign pop = state == IDLE && count != '0;
   assign tick = cnt == LAST;
   assign out_ready = !full;
   assign fifo_count = count;
   always_ff @(posedge clk)
      if (push) mem[wptr] <= output_data;
   // a write at a full edge is dropped even if the FSM pops at the same edge
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
         overflow <= (out_valid && full) ? 1'b1 : clear_overflow ? 1'b0 : overflow;
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shreg <= '0;
         tx <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pop) begin
               shreg <= mem[rptr];
               state <= START;
               tx <= 1'b0;
               tx_busy <= 1'b1;
               cnt <= '0;
            end
            START: if (tick) begin
               state <= DATA;
               cnt <= '0;
               bit_idx <= '0;
               tx <= shreg[0];
            end else cnt <= cnt + 1'b1;
            DATA: if (tick) begin
               cnt <= '0;
               if (bit_idx == 3'd3) begin
                  state <= STOP;
                  tx <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  shreg <= shreg >> 1;
                  tx <= shreg[1];
               end
            end else cnt <= cnt + 1'b1;
            STOP: if (tick) begin
               state <= IDLE;
               tx_busy <= 1'b0;
               cnt <= '0;
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_output_serializer.sv
// tb_output_serializer: directed stimulus against a queue/frame-level model,
// checked every cycle, plus literal expectations for the key scenarios.
module tb_output_serializer;
   localparam int CPB = 4;
   localparam int DEPTH = 8;
   localparam int FLEN = 6 * CPB;
   logic clk = 0, reset = 0, out_valid = 0, clear_overflow = 0;
   logic [3:0] output_data = '0;
   logic out_ready, tx, tx_busy, overflow;
   logic [3:0] fifo_count;
   int vectors = 0, errors = 0;

   output_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .output_data(output_data), .out_valid(out_valid),
      .out_ready(out_ready), .clear_overflow(clear_overflow), .tx(tx), .tx_busy(tx_busy),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a queue of buffered nibbles and the 24-sample waveform of the frame in flight
   logic [3:0] q[$];
   logic [FLEN-1:0] frame;
   int pos = 0;
   bit m_busy = 0, m_ovf = 0;

   always @(posedge clk or negedge reset)
      if (!reset) begin
         q.delete();
         m_busy = 0;
         m_ovf = 0;
         pos = 0;
      end else begin
         automatic bit full = q.size() == DEPTH;
         automatic logic [3:0] d;
         if (m_busy) begin
            pos++;
            if (pos == FLEN) m_busy = 0;
         end else if (q.size() > 0) begin
            d = q.pop_front();
            for (int i = 0; i < FLEN; i++)
               frame[i] = i < CPB ? 1'b0 : i < 5 * CPB ? d[(i - CPB) / CPB] : 1'b1;
            m_busy = 1;
            pos = 0;
         end
         if (out_valid && !full) q.push_back(output_data);
         if (out_valid && full) m_ovf = 1;
         else if (clear_overflow) m_ovf = 0;
      end

   always @(negedge clk) begin
      check("tx", tx, m_busy ? frame[pos] : 1'b1);
      check("tx_busy", tx_busy, m_busy);
      check("fifo_count", fifo_count, q.size());
      check("overflow", overflow, m_ovf);
      check("out_ready", out_ready, q.size() < DEPTH);
   end

   initial begin
      logic [FLEN-1:0] seq;
      int busy_cycles;
      repeat (3) @(negedge clk);
      reset = 1;
      // idle after reset
      repeat (50) @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_count", fifo_count, 4'd0);
      // single frame of 4'hA
      out_valid = 1; output_data = 4'hA;
      @(negedge clk);
      out_valid = 0;
      check("single_count", fifo_count, 4'd1);
      seq = '0;
      busy_cycles = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i < FLEN) seq[i] = tx;
         if (tx_busy) busy_cycles++;
      end
      check("frame_A_wave", seq, 24'hFF0F00);
      check("frame_A_busy", busy_cycles, FLEN);
      // burst of ten pushes: 4'hA is dropped
      for (int v = 1; v <= 10; v++) begin
         out_valid = 1; output_data = 4'(v);
         @(negedge clk);
      end
      check("burst_count", fifo_count, 4'd8);
      check("burst_ovf", overflow, 1'b1);
      check("burst_ready", out_ready, 1'b0);
      // clear coincident with another drop: set wins
      clear_overflow = 1; output_data = 4'h7;
      @(negedge clk);
      check("clr_vs_set", overflow, 1'b1);
      out_valid = 0;
      @(negedge clk);
      check("clr_alone", overflow, 1'b0);
      clear_overflow = 0;
      repeat (9 * (FLEN + 1) + 10) @(negedge clk);
      check("drained", fifo_count, 4'd0);
      // push coinciding with the idle pop keeps count at 1
      out_valid = 1; output_data = 4'h5;
      @(negedge clk);
      output_data = 4'hC;
      @(negedge clk);
      out_valid = 0;
      check("push_pop_count", fifo_count, 4'd1);
      check("push_pop_busy", tx_busy, 1'b1);
      repeat (2 * (FLEN + 1) + 5) @(negedge clk);
      // reset during data bit 2 of 4'h3 (bit value 0)
      out_valid = 1; output_data = 4'h3;
      @(negedge clk);
      output_data = 4'h6;
      @(negedge clk);
      out_valid = 0;
      repeat (13) @(negedge clk);
      check("pre_reset_tx", tx, 1'b0);
      check("pre_reset_count", fifo_count, 4'd1);
      #1 reset = 0;
      #1;
      check("async_tx", tx, 1'b1);
      check("async_count", fifo_count, 4'd0);
      check("async_busy", tx_busy, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (50) @(negedge clk);
      check("post_reset_tx", tx, 1'b1);
      check("post_reset_busy", tx_busy, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
